// File: rtl/multiword_add_sequencer_pkg.sv
// Shared definitions for the multi-word add sequencer: FSM encoding and counter sizing.
package multiword_add_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Word counter width; never narrower than one bit so WORDS=1 still has a counter.
  function automatic int unsigned cnt_width(input int unsigned words);
    int unsigned w;
    w = $clog2(words);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/multiword_add_sequencer_word_adder_cin.sv
// One word of the sequenced add: operand add, then carry-in add, carries OR-ed.
module word_adder_cin #(
  parameter int unsigned NUMBITS = 8
) (
  input  logic [NUMBITS-1:0] a_i,
  input  logic [NUMBITS-1:0] b_i,
  input  logic               cin_i,
  output logic [NUMBITS-1:0] sum_o,
  output logic               cout_o
);

  logic [NUMBITS-1:0] s1;
  logic               c1;
  logic               c2;
  logic [NUMBITS-1:0] cin_ext;

  assign cin_ext = {{(NUMBITS - 1){1'b0}}, cin_i};

  ripple_carry_adder #(
    .NUMBITS (NUMBITS)
  ) u_op_add (
    .a_i        (a_i),
    .b_i        (b_i),
    .carryin_i  (1'b0),
    .sum_o      (s1),
    .carryout_o (c1)
  );

  ripple_carry_adder #(
    .NUMBITS (NUMBITS)
  ) u_cin_add (
    .a_i        (s1),
    .b_i        (cin_ext),
    .carryin_i  (1'b0),
    .sum_o      (sum_o),
    .carryout_o (c2)
  );

  // c1 and c2 are mutually exclusive, so OR is the exact carry.
  assign cout_o = c1 | c2;

endmodule

// File: rtl/ripple_carry_adder.sv
// Plain NUMBITS-wide ripple-carry adder with carry in and carry out.
module ripple_carry_adder #(
  parameter int unsigned NUMBITS = 8
) (
  input  logic [NUMBITS-1:0] a_i,
  input  logic [NUMBITS-1:0] b_i,
  input  logic               carryin_i,
  output logic [NUMBITS-1:0] sum_o,
  output logic               carryout_o
);

  logic [NUMBITS:0] carry;

  // Full-adder chain, LSB first.
  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = carryin_i;
    for (int i = 0; i < int'(NUMBITS); i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign carryout_o = carry[NUMBITS];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Adds two WORDS*NUMBITS operands one word per cycle through a shared NUMBITS adder.
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int unsigned NUMBITS = 8,
  parameter int unsigned WORDS   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic [WORDS*NUMBITS-1:0]   a_i,
  input  logic [WORDS*NUMBITS-1:0]   b_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [WORDS*NUMBITS-1:0]   result_o,
  output logic                       carryout_o
);

  localparam int unsigned CntW = cnt_width(WORDS);
  localparam logic [CntW-1:0] LastCnt = CntW'(WORDS - 1);

  state_e state_q, state_d;
  logic [CntW-1:0]                   cnt_q, cnt_d;
  logic                              carry_q, carry_d;
  logic [WORDS-1:0][NUMBITS-1:0]     op_a_q, op_a_d;
  logic [WORDS-1:0][NUMBITS-1:0]     op_b_q, op_b_d;
  logic [WORDS-1:0][NUMBITS-1:0]     acc_q, acc_d;
  logic [WORDS*NUMBITS-1:0]          result_q, result_d;
  logic                              carryout_q, carryout_d;

  logic [NUMBITS-1:0]                word_sum;
  logic                              word_cout;
  logic                              accept;
  logic                              last_word;

  // Start is only honoured outside RUN; DONE accepts exactly like IDLE.
  assign accept    = start_i && (state_q != StRun);
  assign last_word = (cnt_q == LastCnt);

  word_adder_cin #(
    .NUMBITS (NUMBITS)
  ) u_word_adder (
    .a_i    (op_a_q[cnt_q]),
    .b_i    (op_b_q[cnt_q]),
    .cin_i  (carry_q),
    .sum_o  (word_sum),
    .cout_o (word_cout)
  );

  // FSM state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = accept ? StRun : StIdle;
      StRun:   state_d = last_word ? StDone : StRun;
      StDone:  state_d = accept ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; decoded from state so reset clears them without waiting for a clock.
  always_comb begin
    busy_o = (state_q == StRun);
    done_o = (state_q == StDone);
  end

  // Datapath next-state: operand capture, per-word accumulate, final result latch.
  always_comb begin
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    acc_d      = acc_q;
    result_d   = result_q;
    carryout_d = carryout_q;
    if (accept) begin
      op_a_d  = a_i;
      op_b_d  = b_i;
      cnt_d   = '0;
      carry_d = 1'b0;
    end else if (state_q == StRun) begin
      acc_d[cnt_q] = word_sum;
      carry_d      = word_cout;
      if (last_word) begin
        result_d   = acc_d;
        carryout_d = word_cout;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      op_a_q     <= '0;
      op_b_q     <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      acc_q      <= '0;
      result_q   <= '0;
      carryout_q <= 1'b0;
    end else begin
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      carryout_q <= carryout_d;
    end
  end

  assign result_o   = result_q;
  assign carryout_o = carryout_q;

endmodule
